// File: rtl/atanh_solver.sv
// Inverse of the Q4.12 tanh PWL model by 16-step successive approximation.
// Optional ATANH_SAT_FLAG_EN adds a sat output flagging |Y| >= 1.0.
module atanh_solver #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] y_in,
    output logic                  busy,
    output logic                  done,
`ifdef ATANH_SAT_FLAG_EN
    output logic                  sat,
`endif
    output logic [DATA_WIDTH-1:0] x_out
);

    localparam logic signed [17:0] ONE = 18'sd1 <<< FRACT_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0] r_u;
    logic [15:0] r_y;
    logic [15:0] r_x;
    logic [3:0]  r_cnt;

    logic [15:0]        w_trial;
    logic [15:0]        w_unext;
    logic signed [17:0] w_y;
    logic signed [17:0] w_f;
    logic               w_take;

    // f(x) with 18-bit signed intermediates; |2x| reaches 0x10000
    function automatic logic signed [17:0] f_eval(input logic [15:0] x);
        logic signed [17:0] x2;
        logic signed [17:0] a;
        logic signed [17:0] s;
        x2 = {x[15], x, 1'b0};
        a  = x2[17] ? -x2 : x2;
        if (a >= 18'sh05000)
            s = ONE;
        else if (a >= 18'sh02600)
            s = (a >>> 5) + 18'sh00D80;
        else if (a >= 18'sh00800)
            s = (a >>> 3) + 18'sh00A00;
        else
            s = (a >>> 2) + 18'sh00800;
        if (!x[15] && (x != 16'h0000))
            return (s <<< 1) - ONE;
        return ONE - (s <<< 1);
    endfunction

    // Trial bit on the offset-binary code u = x + 0x8000
    assign w_trial = r_u | (16'h0001 << r_cnt);
    assign w_y     = {{2{r_y[15]}}, r_y};
    assign w_f     = f_eval(w_trial ^ 16'h8000);
    assign w_take  = (w_f <= w_y);
    assign w_unext = w_take ? w_trial : r_u;

    assign busy  = (r_state == SEARCH);
    assign done  = (r_state == DONE);
    assign x_out = r_x;

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SEARCH;
            SEARCH:  if (r_cnt == 4'd0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_u   <= 16'h0000;
            r_y   <= 16'h0000;
            r_x   <= 16'h0000;
            r_cnt <= 4'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_y   <= y_in;
                        r_u   <= 16'h0000;
                        r_cnt <= 4'd15;
                    end
                end
                SEARCH: begin
                    r_u   <= w_unext;
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd0)
                        r_x <= w_unext ^ 16'h8000;
                end
                default: ;
            endcase
        end
    end

`ifdef ATANH_SAT_FLAG_EN
    logic r_sat;

    always_ff @(posedge clk) begin
        if (!rst)
            r_sat <= 1'b0;
        else if (r_state == SEARCH && r_cnt == 4'd0)
            r_sat <= ($signed(r_y) >= 16'sh1000) ||
                     ($signed(r_y) <= 16'shF000);
    end

    assign sat = r_sat;
`endif

endmodule

// File: tb/tb_atanh_solver.sv
// Directed-vector bench for atanh_solver: table of Y->X results,
// start-ignore, mid-search reset, back-to-back and a brute-force sweep.
module tb_atanh_solver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] y_in = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] x_out;
`ifdef ATANH_SAT_FLAG_EN
    logic        sat;
`endif

    int n_pass = 0;
    int n_total = 0;

    atanh_solver dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
`ifdef ATANH_SAT_FLAG_EN
        .sat   (sat),
`endif
        .x_out (x_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        logic [15:0] x;
        logic        s;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic int fm(input int x);
        int a;
        int s;
        a = (x < 0) ? -2 * x : 2 * x;
        if (a >= 20480)      s = 4096;
        else if (a >= 9728)  s = (a >> 5) + 3456;
        else if (a >= 2048)  s = (a >> 3) + 2560;
        else                 s = (a >> 2) + 2048;
        return (x > 0) ? 2 * s - 4096 : 4096 - 2 * s;
    endfunction

    function automatic logic [15:0] ref_x(input int y);
        for (int x = 32767; x >= -32768; x--)
            if (fm(x) <= y) return 16'(x);
        return 16'h8000;
    endfunction

    // Launch one search; k counts negedges after the accepting edge
    task automatic run(input logic [15:0] y, input int rep_k,
                       input int rst_k, output int lat, output int ndone,
                       output logic [15:0] xo, output logic busy_ok,
                       output logic stable);
        logic [15:0] prev;
        logic        exp_busy;
        prev = x_out;
        @(negedge clk);
        start = 1'b1;
        y_in = y;
        lat = -1;
        ndone = 0;
        xo = 16'h0000;
        busy_ok = 1'b1;
        stable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == rep_k) begin
                start = 1'b1;
                y_in = 16'h0800;
            end
            if (k == rep_k + 1) start = 1'b0;
            if (k == rst_k) rst = 1'b0;
            if (k == rst_k + 1) rst = 1'b1;
            exp_busy = (k <= 16) && (k <= rst_k);
            if (busy !== exp_busy) busy_ok = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    xo = x_out;
                end
            end
            if (lat < 0 && k <= rst_k && x_out !== prev) stable = 1'b0;
        end
    endtask

    int          lat;
    int          nd;
    logic [15:0] xo;
    logic        bok;
    logic        stb;
    int          d1;
    int          d2;
    int          yi;
    logic [15:0] yr;

    initial begin
        tbl[0] = '{16'h0000, 16'h0001, 1'b0};
        tbl[1] = '{16'h0800, 16'h0803, 1'b0};
        tbl[2] = '{16'hF800, 16'hF800, 1'b0};
        tbl[3] = '{16'h1000, 16'h7FFF, 1'b1};
        tbl[4] = '{16'hE000, 16'h8000, 1'b1};
        tbl[5] = '{16'h7FFF, 16'h7FFF, 1'b1};
        tbl[6] = '{16'hF000, 16'hD800, 1'b1};
        tbl[7] = '{16'h0FFF, 16'h27FF, 1'b0};
        tbl[8] = '{16'h0001, 16'h0001, 1'b0};
        tbl[9] = '{16'hFFFF, 16'hFFFE, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_x", int'(x_out), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run(tbl[i].y, 999, 999, lat, nd, xo, bok, stb);
            chk($sformatf("vec%0d_x", i), int'(xo), int'(tbl[i].x));
            chk($sformatf("vec%0d_lat", i), lat, 17);
            chk($sformatf("vec%0d_busy", i), int'(bok), 1);
            chk($sformatf("vec%0d_hold", i), int'(stb), 1);
            chk($sformatf("vec%0d_ndone", i), nd, 1);
`ifdef ATANH_SAT_FLAG_EN
            chk($sformatf("vec%0d_sat", i), int'(sat), int'(tbl[i].s));
`endif
        end

        // x_out holds after done
        chk("hold_after_done", int'(x_out), 16'hFFFE);

        // start re-pulse mid-search is ignored
        run(16'h0000, 5, 999, lat, nd, xo, bok, stb);
        chk("ignore_x", int'(xo), 16'h0001);
        chk("ignore_ndone", nd, 1);
        chk("ignore_lat", lat, 17);
        chk("ignore_busy", int'(bok), 1);
        chk("ignore_final_x", int'(x_out), 16'h0001);

        // reset at busy cycle 8 aborts silently
        run(16'h0000, 999, 8, lat, nd, xo, bok, stb);
        chk("abort_ndone", nd, 0);
        chk("abort_busy", int'(bok), 1);
        chk("abort_x", int'(x_out), 16'h0000);
`ifdef ATANH_SAT_FLAG_EN
        chk("abort_sat", int'(sat), 0);
`endif
        run(16'h0800, 999, 999, lat, nd, xo, bok, stb);
        chk("post_rst_x", int'(xo), 16'h0803);
        chk("post_rst_lat", lat, 17);

        // start held high: 18-cycle period
        @(negedge clk);
        start = 1'b1;
        y_in = 16'hF800;
        d1 = -1;
        d2 = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        start = 1'b0;
        chk("b2b_first", d1, 17);
        chk("b2b_period", d2 - d1, 18);
        repeat (40) @(negedge clk);
        chk("b2b_x", int'(x_out), 16'hF800);

        // brute-force sweep away from the PWL dip near |Y|=0xD60..0xD7E
        for (int i = 0; i < 16; i++) begin
            do begin
                yr = 16'($urandom);
                yi = int'($signed(yr));
            end while ((yi >= 32'sh0D50 && yi <= 32'sh0D90) ||
                       (yi <= -32'sh0D50 && yi >= -32'sh0D90));
            run(yr, 999, 999, lat, nd, xo, bok, stb);
            chk($sformatf("rnd_y%04h_x", yr), int'(xo), int'(ref_x(yi)));
            chk($sformatf("rnd_y%04h_lat", yr), lat, 17);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
